// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline hazard controller for the 5-stage MIPS core.
// Drives PC hold and IF/ID, ID/EX hold/clear from load-use, RAW and
// mult/div hazards; a taken branch flushes and overrides any stall.
// Tracks the multi-cycle mult/div unit with a small FSM plus down-counter.
// Optional feature: define HAZARD_FWD_EN to get EX-stage forwarding selects
// and drop the non-load RAW stalls.
module hazard_ctl #(
    parameter int RW        = 5,
    parameter int MD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          id_md_start,
    input  logic          id_md_read,
    input  logic [RW-1:0] ex_rs,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_branch_taken,
    input  logic [RW-1:0] mem_rd,
    input  logic [RW-1:0] wb_rd,
    input  logic          mem_regwrite,
    input  logic          wb_regwrite,
    output logic          hold_pc,
    output logic          hold_ifid,
    output logic          clear_ifid,
    output logic          clear_idex,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          md_busy
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    md_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic rs_live, rt_live;
    logic ex_hit, mem_hit;
    logic load_use, raw_stall, md_stall, stall;

    // Register 0 is hardwired zero, so a source of $0 never creates a dependency.
    assign rs_live = id_uses_rs && (id_rs != '0);
    assign rt_live = id_uses_rt && (id_rt != '0);

    assign ex_hit  = (rs_live && (id_rs == ex_rd))  || (rt_live && (id_rt == ex_rd));
    assign mem_hit = (rs_live && (id_rs == mem_rd)) || (rt_live && (id_rt == mem_rd));

    assign load_use = ex_memread && ex_regwrite && ex_hit;
    assign md_stall = md_busy && (id_md_start || id_md_read);

`ifdef HAZARD_FWD_EN
    assign raw_stall = 1'b0;

    // EX operand A select; the younger MEM result wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (ex_rs == mem_rd))
            fwd_a = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (ex_rs == wb_rd))
            fwd_a = 2'b01;
    end

    // EX operand B select; same priority as operand A.
    always_comb begin
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (ex_rt == mem_rd))
            fwd_b = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (ex_rt == wb_rd))
            fwd_b = 2'b01;
    end
`else
    // Without forwarding, wait until the producer reaches WB; the regfile
    // writes in the first half-cycle so a WB match needs no stall.
    assign raw_stall = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    assign stall = load_use || raw_stall || md_stall;

    // Mult/div FSM state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: accept a mult/div only when it actually leaves ID; a flush
    // after acceptance does not abort it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (id_md_start && !stall && !ex_branch_taken) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MD_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: flush beats stall; a stall freezes PC and IF/ID and bubbles ID/EX.
    always_comb begin
        md_busy    = (state == BUSY);
        hold_pc    = 1'b0;
        hold_ifid  = 1'b0;
        clear_ifid = 1'b0;
        clear_idex = 1'b0;
        if (ex_branch_taken) begin
            clear_ifid = 1'b1;
            clear_idex = 1'b1;
        end else if (stall) begin
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            clear_idex = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed testbench for hazard_ctl (default MD_CYCLES=4).
// Control vector ctl = {hold_pc, hold_ifid, clear_ifid, clear_idex}.
module tb_hazard_ctl;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rs, id_uses_rt, id_md_start, id_md_read;
    logic          ex_regwrite, ex_memread, ex_branch_taken;
    logic          mem_regwrite, wb_regwrite;
    logic          hold_pc, hold_ifid, clear_ifid, clear_idex, md_busy;
    logic [1:0]    fwd_a, fwd_b;
    logic [3:0]    ctl;

    int checks   = 0;
    int failures = 0;

    assign ctl = {hold_pc, hold_ifid, clear_ifid, clear_idex};

    always #5 clk = ~clk;

    hazard_ctl #(.RW(RW), .MD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .hold_pc(hold_pc), .hold_ifid(hold_ifid),
        .clear_ifid(clear_ifid), .clear_idex(clear_idex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
    );

    task automatic zero_inputs();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_md_start = 0; id_md_read = 0;
        ex_regwrite = 0; ex_memread = 0; ex_branch_taken = 0;
        mem_regwrite = 0; wb_regwrite = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        zero_inputs();
        #12;
        checks++;
        if ({ctl, fwd_a, fwd_b, md_busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {ctl, fwd_a, fwd_b, md_busy}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({ctl, md_busy} !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=%b", {ctl, md_busy}, 5'b0);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        zero_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd2; id_rs = 5'd2; id_uses_rs = 1;
        #1;
        checks++;
        if (ctl !== 4'b1101) begin
            failures++;
            $display("FAIL load_use got=%b exp=%b", ctl, 4'b1101);
        end
        id_uses_rs = 0;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            failures++;
            $display("FAIL load_use_unused_src got=%b exp=%b", ctl, 4'b0000);
        end
        id_uses_rs = 1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            failures++;
            $display("FAIL load_use_reg0 got=%b exp=%b", ctl, 4'b0000);
        end
        ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1;
        #1;
        checks++;
        if (ctl !== 4'b1101) begin
            failures++;
            $display("FAIL load_use_rt got=%b exp=%b", ctl, 4'b1101);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        zero_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd2; id_rs = 5'd2; id_uses_rs = 1;
        ex_branch_taken = 1;
        #1;
        checks++;
        if (ctl !== 4'b0011) begin
            failures++;
            $display("FAIL flush_over_stall got=%b exp=%b", ctl, 4'b0011);
        end
    endtask

    task automatic test_raw();
        logic [3:0] exp_mem;
        @(negedge clk);
        zero_inputs();
        id_rt = 5'd5; id_uses_rt = 1; mem_rd = 5'd5; mem_regwrite = 1;
`ifdef HAZARD_FWD_EN
        exp_mem = 4'b0000;
`else
        exp_mem = 4'b1101;
`endif
        #1;
        checks++;
        if (ctl !== exp_mem) begin
            failures++;
            $display("FAIL raw_mem_rt got=%b exp=%b", ctl, exp_mem);
        end
        id_rt = 5'd0; mem_rd = 5'd0;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            failures++;
            $display("FAIL raw_reg0 got=%b exp=%b", ctl, 4'b0000);
        end
        zero_inputs();
        id_rs = 5'd9; id_uses_rs = 1; ex_rd = 5'd9; ex_regwrite = 1;
        #1;
        checks++;
        if (ctl !== exp_mem) begin
            failures++;
            $display("FAIL raw_ex_rs got=%b exp=%b", ctl, exp_mem);
        end
        zero_inputs();
        id_rs = 5'd9; id_uses_rs = 1; wb_rd = 5'd9; wb_regwrite = 1;
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            failures++;
            $display("FAIL raw_wb_nostall got=%b exp=%b", ctl, 4'b0000);
        end
    endtask

    task automatic test_forward();
        logic [3:0] exp1, exp2, exp3;
        @(negedge clk);
        zero_inputs();
        ex_rs = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3; mem_regwrite = 1; wb_regwrite = 1;
        ex_rt = 5'd4;
`ifdef HAZARD_FWD_EN
        exp1 = 4'b1000; exp2 = 4'b0100; exp3 = 4'b0001;
`else
        exp1 = 4'b0000; exp2 = 4'b0000; exp3 = 4'b0000;
`endif
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== exp1) begin
            failures++;
            $display("FAIL fwd_mem_priority got=%b exp=%b", {fwd_a, fwd_b}, exp1);
        end
        mem_rd = 5'd0;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== exp2) begin
            failures++;
            $display("FAIL fwd_wb got=%b exp=%b", {fwd_a, fwd_b}, exp2);
        end
        ex_rs = 5'd0; wb_rd = 5'd0; ex_rt = 5'd6; wb_rd = 5'd6;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== exp3) begin
            failures++;
            $display("FAIL fwd_b_wb got=%b exp=%b", {fwd_a, fwd_b}, exp3);
        end
    endtask

    task automatic test_md_busy();
        @(negedge clk);
        zero_inputs();
        id_md_start = 1;
        #1;
        checks++;
        if ({ctl, md_busy} !== 5'b0) begin
            failures++;
            $display("FAIL md_accept_nostall got=%b exp=%b", {ctl, md_busy}, 5'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_md_start = 0; id_md_read = 1;
            ex_branch_taken = (i == 1);
            #1;
            checks++;
            if ({md_busy, ctl} !== ((i == 1) ? 5'b10011 : 5'b11101)) begin
                failures++;
                $display("FAIL md_busy_cycle%0d got=%b exp=%b", i, {md_busy, ctl},
                         ((i == 1) ? 5'b10011 : 5'b11101));
            end
        end
        @(negedge clk);
        ex_branch_taken = 0;
        #1;
        checks++;
        if ({md_busy, ctl} !== 5'b0) begin
            failures++;
            $display("FAIL md_release got=%b exp=%b", {md_busy, ctl}, 5'b0);
        end
    endtask

    task automatic test_md_reject();
        @(negedge clk);
        zero_inputs();
        id_md_start = 1; ex_branch_taken = 1;
        @(negedge clk);
        ex_branch_taken = 0; id_md_start = 0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL md_flushed_not_accepted got=%b exp=%b", md_busy, 1'b0);
        end
        id_md_start = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd8;
        id_rs = 5'd8; id_uses_rs = 1;
        @(negedge clk);
        zero_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL md_stalled_not_accepted got=%b exp=%b", md_busy, 1'b0);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        zero_inputs();
        id_md_start = 1;
        @(negedge clk);
        id_md_start = 0; id_md_read = 1;
        @(negedge clk);
        #1;
        checks++;
        if ({md_busy, ctl} !== 5'b11101) begin
            failures++;
            $display("FAIL busy_before_reset got=%b exp=%b", {md_busy, ctl}, 5'b11101);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({md_busy, ctl} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset_busy got=%b exp=%b", {md_busy, ctl}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_midreset got=%b exp=%b", md_busy, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush();
        test_raw();
        test_forward();
        test_md_busy();
        test_md_reject();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
